// File: rtl/alu_cmd_seq.sv
// Command sequencer driving the serial operand protocol of the 16-bit ALU.
// Optional WAIT-state abort counter enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_cmd_seq #(
    parameter int unsigned W              = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_lo,
    output logic [W-1:0] rsp_hi,
    output logic         rsp_ovf,
    output logic         rsp_err,
    output logic         alu_start,
    output logic [1:0]   alu_s,
    output logic [W-1:0] alu_inbus,
    input  logic [W-1:0] alu_outbus,
    input  logic         alu_finish,
    input  logic         alu_overflow,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOAD_M,
        S_LOAD_Q,
        S_WAIT,
        S_CAP2,
        S_RESP
    } state_t;

    state_t         r_state;
    logic [1:0]     r_op;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_req_ready;
    logic           r_busy;
    logic           r_start;
    logic [1:0]     r_s;
    logic [W-1:0]   r_inbus;
    logic           r_rsp_valid;
    logic [W-1:0]   r_lo;
    logic [W-1:0]   r_hi;
    logic           r_ovf;
    logic           w_two_word;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic           r_err;
    logic [CW-1:0]  r_cnt;
    assign rsp_err = r_err;
`else
    logic           w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign rsp_err = 1'b0;
`endif

    // mul/div return two words: high/remainder first, then low/quotient
    assign w_two_word = r_op[1];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_start     <= 1'b0;
            r_s         <= '0;
            r_inbus     <= '0;
            r_rsp_valid <= 1'b0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_ovf       <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
            r_err       <= 1'b0;
            r_cnt       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_op        <= req_op;
                        r_a         <= req_a;
                        r_b         <= req_b;
                        r_s         <= req_op;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
`ifdef ALU_SEQ_TIMEOUT_EN
                        r_err       <= 1'b0;
`endif
                        r_state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_start <= 1'b1;
                    r_inbus <= r_a;
                    r_state <= S_LOAD_M;
                end
                S_LOAD_M: begin
                    r_start <= 1'b0;
                    r_inbus <= r_b;
                    r_state <= S_LOAD_Q;
                end
                S_LOAD_Q: begin
                    r_inbus <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // finish has priority over a timeout reached in the same cycle
                    if (alu_finish) begin
                        if (w_two_word) begin
                            r_hi    <= alu_outbus;
                            r_ovf   <= 1'b0;
                            r_state <= S_CAP2;
                        end else begin
                            r_lo        <= alu_outbus;
                            r_hi        <= '0;
                            r_ovf       <= alu_overflow;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
`ifdef ALU_SEQ_TIMEOUT_EN
                    else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_lo        <= '0;
                        r_hi        <= '0;
                        r_ovf       <= 1'b0;
                        r_err       <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_CAP2: begin
                    r_lo        <= alu_outbus;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_s         <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign busy      = r_busy;
    assign alu_start = r_start;
    assign alu_s     = r_s;
    assign alu_inbus = r_inbus;
    assign rsp_valid = r_rsp_valid;
    assign rsp_lo    = r_lo;
    assign rsp_hi    = r_hi;
    assign rsp_ovf   = r_ovf;

endmodule
